// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU operation sequencer.
package alu_seq_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NREGS = 4;
    localparam int unsigned AW    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHL   = 2'b10;
    localparam logic [1:0] GRP_SHR   = 2'b11;

    // Only the arithmetic group produces a meaningful carry.
    function automatic logic updates_carry(input logic [3:0] op);
        return op[3:2] == GRP_ARITH;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x4 register file: two async read ports, write-back port, load port.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data
);

    logic [WIDTH-1:0] regs [NREGS];

    // Write-back takes priority over a load to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wb_en && wb_addr == AW'(i)) begin
                    regs[i] <= wb_data;
                end else if (ld_en && ld_addr == AW'(i)) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts micro-ops, drives the ALU for one cycle, writes back result and flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             cmd_cin,
    input  logic             cmd_use_cf,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    output logic             alu_sel0,
    output logic             alu_sel1,
    output logic             alu_sel2,
    output logic             alu_sel3,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_dst,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry_flag,
    output logic             zero_flag
);

    state_e           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    alu_seq_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (cmd_srca),
        .raddr_b (cmd_srcb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .wb_en   (state == ST_EXEC),
        .wb_addr (dst_q),
        .wb_data (alu_f),
        .ld_en   (load_en),
        .ld_addr (load_addr),
        .ld_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            dst_q      <= '0;
            wb_valid   <= 1'b0;
            wb_dst     <= '0;
            wb_data    <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Operand latches only move on accept, so ALU ports hold otherwise.
                    if (cmd_valid) begin
                        state <= ST_EXEC;
                        op_q  <= cmd_op;
                        a_q   <= rdata_a;
                        b_q   <= rdata_b;
                        cin_q <= cmd_use_cf ? carry_flag : cmd_cin;
                        dst_q <= cmd_dst;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_WB;
                    wb_valid  <= 1'b1;
                    wb_dst    <= dst_q;
                    wb_data   <= alu_f;
                    zero_flag <= (alu_f == '0);
                    if (updates_carry(op_q)) begin
                        carry_flag <= alu_cout;
                    end
                end
                ST_WB: begin
                    state    <= ST_IDLE;
                    wb_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign alu_sel0  = op_q[0];
    assign alu_sel1  = op_q[1];
    assign alu_sel2  = op_q[2];
    assign alu_sel3  = op_q[3];
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU model attached.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [1:0] cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
    logic       cmd_cin = 1'b0, cmd_use_cf = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [3:0] load_data = '0;
    logic       alu_sel0, alu_sel1, alu_sel2, alu_sel3;
    logic [3:0] alu_a, alu_b, alu_f;
    logic       alu_cin, alu_cout;
    logic       wb_valid;
    logic [1:0] wb_dst;
    logic [3:0] wb_data;
    logic       carry_flag, zero_flag;

    int tests = 0;
    int fails = 0;
    int wb_seen = 0;

    typedef struct packed {
        logic [1:0] dst;
        logic [3:0] data;
        logic       cf;
        logic       zf;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_dst    (cmd_dst),
        .cmd_cin    (cmd_cin),
        .cmd_use_cf (cmd_use_cf),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .alu_sel0   (alu_sel0),
        .alu_sel1   (alu_sel1),
        .alu_sel2   (alu_sel2),
        .alu_sel3   (alu_sel3),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_f      (alu_f),
        .alu_cout   (alu_cout),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    // ALU model: 00xx add/sub/inc/dec, 01xx and/or/xor/not, 10xx shl, 11xx shr.
    logic [3:0] sel;
    logic [4:0] sum;
    assign sel = {alu_sel3, alu_sel2, alu_sel1, alu_sel0};
    always_comb begin
        sum      = '0;
        alu_f    = '0;
        alu_cout = 1'b0;
        case (sel[3:2])
            2'b00: begin
                case (sel[1:0])
                    2'b00:   sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                    2'b01:   sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
                    2'b10:   sum = {1'b0, alu_a} + {4'b0, alu_cin};
                    default: sum = {1'b0, alu_a} + 5'h0F + {4'b0, alu_cin};
                endcase
                alu_f    = sum[3:0];
                alu_cout = sum[4];
            end
            2'b01: begin
                case (sel[1:0])
                    2'b00:   alu_f = alu_a & alu_b;
                    2'b01:   alu_f = alu_a | alu_b;
                    2'b10:   alu_f = alu_a ^ alu_b;
                    default: alu_f = ~alu_a;
                endcase
            end
            2'b10: begin
                alu_f    = {alu_a[2:0], 1'b0};
                alu_cout = alu_a[3];
            end
            default: begin
                alu_f    = {1'b0, alu_a[3:1]};
                alu_cout = alu_a[0];
            end
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rd_reg(input int i);
        return int'(u_dut.u_rf.regs[i]);
    endfunction

    // Monitor: pops one expectation per write-back pulse.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            wb_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_wb", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_dst", int'(wb_dst), int'(e.dst));
                chk("wb_data", int'(wb_data), int'(e.data));
                chk("carry_flag", int'(carry_flag), int'(e.cf));
                chk("zero_flag", int'(zero_flag), int'(e.zf));
            end
        end
    end

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
    endtask

    // mode 1: load srca at the accept edge; mode 2: load dst at the write-back edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] dst, input logic cin, input logic ucf,
                         input int mode, input logic [3:0] ld,
                         input int ea, input int eb, input int ecin,
                         input logic [3:0] edata, input logic ecf, input logic ezf);
        exp_t e;
        @(negedge clk);
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_srca   = sa;
        cmd_srcb   = sb;
        cmd_dst    = dst;
        cmd_cin    = cin;
        cmd_use_cf = ucf;
        if (mode == 1) begin
            load_en = 1'b1; load_addr = sa; load_data = ld;
        end
        e = '{dst: dst, data: edata, cf: ecf, zf: ezf};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        load_en   = 1'b0;
        chk("alu_cin_early", int'(alu_cin), ecin);
        @(negedge clk);
        chk("ready_in_exec", int'(cmd_ready), 0);
        chk("alu_sel", int'(sel), int'(op));
        chk("alu_a", int'(alu_a), ea);
        chk("alu_b", int'(alu_b), eb);
        chk("alu_cin", int'(alu_cin), ecin);
        if (mode == 2) begin
            load_en = 1'b1; load_addr = dst; load_data = ld;
        end
        @(posedge clk);
        #1 load_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_wb", int'(cmd_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int seen0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_flags", int'({carry_flag, zero_flag}), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        rst_n = 1'b1;

        // Add
        load(2'd1, 4'd4);
        load(2'd2, 4'd2);
        issue(4'b0000, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 0, 4'd0, 4, 2, 0, 4'd6, 1'b0, 1'b0);
        chk("r0_add", rd_reg(0), 6);

        // Carry and zero, then XOR keeps carry
        load(2'd1, 4'd15);
        load(2'd2, 4'd1);
        issue(4'b0000, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 0, 4'd0, 15, 1, 0, 4'd0, 1'b1, 1'b1);
        load(2'd1, 4'd4);
        load(2'd2, 4'd2);
        issue(4'b0110, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 0, 4'd0, 4, 2, 0, 4'd6, 1'b1, 1'b0);

        // Shifts; second one reads R2=8 written by the first
        issue(4'b1000, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 0, 4'd0, 4, 2, 0, 4'd8, 1'b1, 1'b0);
        issue(4'b1100, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 0, 4'd0, 4, 8, 0, 4'd2, 1'b1, 1'b0);

        // Carry chaining from the flag
        issue(4'b0000, 2'd1, 2'd2, 2'd0, 1'b0, 1'b1, 0, 4'd0, 4, 2, 1, 4'd7, 1'b0, 1'b0);

        // Back-to-back with valid held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_srca = 2'd1; cmd_srcb = 2'd2;
        cmd_dst = 2'd0; cmd_cin = 1'b0; cmd_use_cf = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (cmd_ready) begin
                acc.push_back(i);
                sb_q.push_back('{dst: 2'd0, data: 4'd6, cf: 1'b0, zf: 1'b0});
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 3);
            chk("b2b_gap2", acc[2] - acc[1], 3);
        end

        // Load collides with write-back: write-back wins
        issue(4'b0000, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 2, 4'd9, 4, 2, 1, 4'd7, 1'b0, 1'b0);
        chk("r3_collide", rd_reg(3), 7);
        // Load to source at accept edge: operand is pre-load value
        issue(4'b0000, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1, 4'd15, 4, 2, 0, 4'd6, 1'b0, 1'b0);
        chk("r1_loaded", rd_reg(1), 15);

        // Reset during EXEC
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_srca = 2'd1; cmd_srcb = 2'd2;
        cmd_dst = 2'd2; cmd_cin = 1'b1; cmd_use_cf = 1'b0;
        seen0 = wb_seen;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_exec", int'(cmd_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_wb_valid", int'(wb_valid), 0);
        for (int i = 0; i < 4; i++) chk("mid_rst_reg", rd_reg(i), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_wb_after_rst", wb_seen - seen0, 0);
        chk("reg2_after_rst", rd_reg(2), 0);
        load(2'd1, 4'd3);
        load(2'd2, 4'd5);
        issue(4'b0000, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 0, 4'd0, 3, 5, 0, 4'd8, 1'b0, 1'b0);
        chk("r2_after_rst_cmd", rd_reg(2), 8);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Sequencing stage directly upstream of `arithmetic_logic_unit`.
- Accepts one micro-operation per command over a valid/ready handshake.
- Reads two operands from a 4-entry x 4-bit register file and drives the ALU select, operand and carry-in ports for one full cycle.
- Writes the ALU result back to the register file and updates the carry and zero flags.

## Interface
- `NREGS`, 4: register-file depth; fixed at 4 because of the 2-bit register addresses.
- `WIDTH`, 4: datapath width; fixed at 4 to match the ALU.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  block can accept a command.
- `CMD_OP`  in  4  {SEL3,SEL2,SEL1,SEL0} passed to the ALU.
- `CMD_SRCA`, `CMD_SRCB`, `CMD_DST`  in  2 each  register addresses for operand A, operand B and the destination.
- `CMD_CIN`  in  1  explicit carry-in.
- `CMD_USE_CF`  in  1  1: use `CARRY_FLAG` as carry-in instead of `CMD_CIN`.
- `LOAD_EN`  in  1  direct register write strobe.
- `LOAD_ADDR`  in  2  register address for the direct write.
- `LOAD_DATA`  in  4  data for the direct write.
- `ALU_SEL0`..`ALU_SEL3`  out  1 each  to the ALU select inputs.
- `ALU_A`, `ALU_B`  out  4  to the ALU operand inputs.
- `ALU_CIN`  out  1  to the ALU carry input.
- `ALU_F`  in  4  ALU result.
- `ALU_COUT`  in  1  ALU carry out.
- `WB_VALID`  out  1  one-cycle pulse marking a completed operation.
- `WB_DST`  out  2  destination register of the completed operation.
- `WB_DATA`  out  4  result written by the completed operation.
- `CARRY_FLAG`  out  1  registered carry flag.
- `ZERO_FLAG`  out  1  registered zero flag.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC on `CMD_VALID && CMD_READY`.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- `CMD_READY` = 1 only in IDLE.
- On accept, latch:
  - op = `CMD_OP`;
  - A = `reg[CMD_SRCA]` and B = `reg[CMD_SRCB]`, both values from before the edge;
  - dst = `CMD_DST`;
  - cin = `CMD_USE_CF ? CARRY_FLAG : CMD_CIN`.
- EXEC: `ALU_*` outputs are driven from the latches and stay stable for the whole cycle.
- End of EXEC:
  - `reg[dst]` <= `ALU_F`;
  - `WB_DATA` <= `ALU_F`;
  - `ZERO_FLAG` <= (`ALU_F` == 0).
- Carry flag: `CARRY_FLAG` <= `ALU_COUT` only when op[3:2] == 2'b00 (arithmetic group). The logic group (01) and the shifts (10, 11) leave it unchanged.
- In IDLE and WB, `ALU_*` outputs hold their last values. No output toggles unless a command is accepted.
- `LOAD_EN` writes `reg[LOAD_ADDR]` in any state.
- Load and write-back to the same register at the same edge: write-back wins.
- Load to a source register at the accept edge: the operand takes the pre-load value.
- `CMD_OP` encodings are forwarded unchecked; all 16 values are legal.

## Timing
- Accept at edge e0; ALU drive during e0->e1; register, flags and `WB_DATA` updated at e1; `WB_VALID` high for e1->e2; `CMD_READY` high again after e2.
- Throughput: 1 command per 3 cycles; back-to-back accepts are spaced 3 edges apart.
- A command that reads the previous command's destination sees the written value, because write-back at e1 precedes the next accept at e3.
- Reset values: `CMD_READY`=1 (state IDLE); every other output, all registers and both flags = 0.
- No command is accepted while `RST_N`=0.
- Reset mid-operation (EXEC or WB): the operation is dropped, no `WB_VALID` is issued, no write-back occurs and state returns to IDLE.

## Structure
- Package `alu_seq_pkg` holds:
  - `WIDTH`, `NREGS`;
  - state encodings `ST_IDLE`=0, `ST_EXEC`=1, `ST_WB`=2;
  - op-group constants `GRP_ARITH`=2'b00, `GRP_LOGIC`=2'b01, `GRP_SHL`=2'b10, `GRP_SHR`=2'b11.
- Sub-module `alu_seq_regfile` contains the 4x4 registers with:
  - two asynchronous read ports;
  - one write-back port;
  - one load port with priority to write-back.
- The FSM and the flag logic stay in the top level.

## Test plan
The bench connects `arithmetic_logic_unit` (or a golden model with the same select decode).

1. Add: load R1=4, R2=2; op 0000, srcA=1, srcB=2, dst=0, cin 0. Required: `ALU_A`=4 and `ALU_B`=2 during EXEC; then `WB_VALID` pulse with `WB_DATA`=6, `WB_DST`=0; R0=6, `CARRY_FLAG`=0, `ZERO_FLAG`=0.
2. Carry and zero: R1=15, R2=1, op 0000. Required: `WB_DATA`=0, `CARRY_FLAG`=1, `ZERO_FLAG`=1. Then an XOR (op 0110) with R1=4, R2=2 gives `WB_DATA`=6 and `CARRY_FLAG` stays 1.
3. Shifts: R1=4 with op 1000 gives 8; R1=4 with op 1100 gives 2. `CARRY_FLAG` is unchanged in both.
4. Carry chaining: `CARRY_FLAG`=1, `CMD_USE_CF`=1, `CMD_CIN`=0. Required: `ALU_CIN`=1 throughout EXEC.
5. Handshake and collision:
   - `CMD_VALID` held high continuously: accepts occur exactly every 3 cycles.
   - `LOAD_EN` targeting the destination at the write-back edge: the register holds the write-back value.
6. Reset mid-operation: assert `RST_N`=0 during EXEC. Required: no `WB_VALID`, all registers 0, `CMD_READY`=1, and the next command executes normally.
